// File: rtl/diff_rx.sv
// Differential-Manchester frame receiver: synchronises the line, times the
// transitions of every bit and emits each good frame with a one-cycle strobe.
module diff_rx #(
  parameter int DATA_PERIOD = 20,
  parameter int DATA_WIDTH  = 26
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  error_out,
  output logic                  busy_out
);

  localparam int Q  = DATA_PERIOD / 4;
  localparam int CW = $clog2(5 * Q + 1);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] C_Q    = CW'(Q);
  localparam logic [CW-1:0] C_3Q   = CW'(3 * Q);
  localparam logic [CW-1:0] C_5Q   = CW'(5 * Q);
  localparam logic [CW-1:0] C_5QM1 = CW'(5 * Q - 1);

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    TAIL
  } state_t;

  state_t                state, state_nx;
  logic                  sync1, sync2, dly;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [BW-1:0]         bitcnt, bitcnt_nx;
  logic                  mid, mid_nx;
  logic [DATA_WIDTH-2:0] shreg, shreg_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic                  valid_nx, error_nx;
  logic                  line_edge, line_rise;

  assign line_edge = sync2 ^ dly;
  assign line_rise = sync2 & ~dly;
  assign busy_out  = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      dly       <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      mid       <= 1'b0;
      shreg     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      sync1     <= data_in;
      sync2     <= sync1;
      dly       <= sync2;
      state     <= state_nx;
      cnt       <= cnt_nx;
      bitcnt    <= bitcnt_nx;
      mid       <= mid_nx;
      shreg     <= shreg_nx;
      data_out  <= data_nx;
      valid_out <= valid_nx;
      error_out <= error_nx;
    end
  end

  // Edge timing within a bit window decides mid transition, boundary or abort.
  always_comb begin
    state_nx  = state;
    cnt_nx    = (cnt == C_5Q) ? cnt : cnt + CW'(1);
    bitcnt_nx = bitcnt;
    mid_nx    = mid;
    shreg_nx  = shreg;
    data_nx   = data_out;
    valid_nx  = 1'b0;
    error_nx  = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (line_rise) begin
          bitcnt_nx = BW'(DATA_WIDTH - 1);
          mid_nx    = 1'b0;
          state_nx  = BIT;
        end
      end
      BIT: begin
        if (line_edge && cnt < C_Q) begin
          error_nx = 1'b1;
        end else if (line_edge && cnt < C_3Q) begin
          if (!mid) mid_nx = 1'b1;
          else      error_nx = 1'b1;
        end else if (line_edge && cnt < C_5Q && bitcnt != '0) begin
          shreg_nx  = {shreg[DATA_WIDTH-3:0], mid};
          bitcnt_nx = bitcnt - BW'(1);
          cnt_nx    = '0;
          mid_nx    = 1'b0;
        end else if (bitcnt == '0 && cnt == C_3Q) begin
          data_nx  = {shreg, mid};
          valid_nx = 1'b1;
          state_nx = TAIL;
        end else if (!line_edge && cnt == C_5QM1 && bitcnt != '0) begin
          error_nx = 1'b1;
        end
        // An aborted frame simply falls back to idle; shreg is overwritten later.
        if (error_nx) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      TAIL: begin
        if (cnt == C_5Q) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_diff_rx.sv
// Bench for diff_rx: a differential-Manchester line model feeds the receiver
// and a scoreboard matches every decoded frame against what was sent.
module tb_diff_rx;

  localparam int W = 26;

  logic         clk_in;
  logic         rst_in;
  logic         data_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         error_out;
  logic         busy_out;

  int checks = 0;
  int failures = 0;
  int pcyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = 0;
  int last_err_cyc = 0;
  int last_bnd = 0;
  logic [W-1:0] last_good = '0;
  logic [W-1:0] exp_q[$];

  diff_rx #(.DATA_PERIOD(20), .DATA_WIDTH(W)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .error_out(error_out),
    .busy_out (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) pcyc <= pcyc + 1;

  // Scoreboard side: every valid strobe pops the oldest frame sent.
  always @(negedge clk_in) begin
    if (valid_out) begin
      valid_cnt++;
      last_valid_cyc = pcyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_valid data_out=%h with no frame outstanding", data_out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("[TB] FAIL frame_data got=%h expected=%h", data_out, e);
        end
      end
    end
    if (error_out) begin
      err_cnt++;
      last_err_cyc = pcyc;
    end
    if (valid_out || error_out) begin
      checks++;
      if (valid_out && error_out) begin
        failures++;
        $display("[TB] FAIL valid_and_error got=1 expected=0");
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic tx_bit(input logic b);
    data_in = ~data_in;
    last_bnd = pcyc;
    repeat (10) @(negedge clk_in);
    if (b) data_in = ~data_in;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic send_bits(input logic [W-1:0] d, input int n);
    for (int i = W - 1; i >= W - n; i--) tx_bit(d[i]);
  endtask

  task automatic send_frame(input logic [W-1:0] d);
    exp_q.push_back(d);
    last_good = d;
    send_bits(d, W);
    data_in = 1'b0;
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    data_in = 1'b0;
    idle(3);
    checks++; if (data_out !== '0) begin failures++; $display("[TB] FAIL reset_data got=%h expected=0", data_out); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b expected=0", valid_out); end
    checks++; if (error_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_error got=%b expected=0", error_out); end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b expected=0", busy_out); end
    rst_in = 1'b1;
    idle(5);
  endtask

  task automatic test_single;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(26'h0BE3219);
    idle(40);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("[TB] FAIL single_valid_count got=%0d expected=1", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("[TB] FAIL single_error_count got=%0d expected=0", err_cnt - e0); end
    checks++; if (last_valid_cyc - last_bnd !== 19) begin failures++; $display("[TB] FAIL single_latency got=%0d expected=19", last_valid_cyc - last_bnd); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL single_outstanding got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_extremes;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(26'h0000000);
    idle(200);
    send_frame(26'h3FFFFFF);
    idle(40);
    checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("[TB] FAIL extremes_valid_count got=%0d expected=2", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("[TB] FAIL extremes_error_count got=%0d expected=0", err_cnt - e0); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL extremes_outstanding got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(26'h2AAAAAA);
    idle(15);
    checks++; if (busy_out !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_gap got=%b expected=0", busy_out); end
    idle(5);
    send_frame(26'h1555555);
    idle(40);
    checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("[TB] FAIL b2b_valid_count got=%0d expected=2", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("[TB] FAIL b2b_error_count got=%0d expected=0", err_cnt - e0); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL b2b_outstanding got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_stuck;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(26'h0BE3219, 10);
    idle(40);
    data_in = 1'b0;
    idle(40);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("[TB] FAIL stuck_error_count got=%0d expected=1", err_cnt - e0); end
    checks++; if (last_err_cyc - last_bnd !== 28) begin failures++; $display("[TB] FAIL stuck_error_time got=%0d expected=28", last_err_cyc - last_bnd); end
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("[TB] FAIL stuck_valid_count got=%0d expected=0", valid_cnt - v0); end
    checks++; if (data_out !== last_good) begin failures++; $display("[TB] FAIL stuck_data_kept got=%h expected=%h", data_out, last_good); end
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(26'h3C0FFEE, 5);
    data_in = ~data_in;
    last_bnd = pcyc;
    idle(2);
    data_in = ~data_in;
    idle(40);
    data_in = 1'b0;
    idle(40);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("[TB] FAIL glitch_error_count got=%0d expected=1", err_cnt - e0); end
    checks++; if (last_err_cyc - last_bnd !== 5) begin failures++; $display("[TB] FAIL glitch_error_time got=%0d expected=5", last_err_cyc - last_bnd); end
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("[TB] FAIL glitch_valid_count got=%0d expected=0", valid_cnt - v0); end
  endtask

  task automatic test_double_mid;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(26'h2345678, 5);
    data_in = ~data_in;
    last_bnd = pcyc;
    idle(10);
    data_in = ~data_in;
    idle(2);
    data_in = ~data_in;
    idle(40);
    data_in = 1'b0;
    idle(40);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("[TB] FAIL dmid_error_count got=%0d expected=1", err_cnt - e0); end
    checks++; if (last_err_cyc - last_bnd !== 15) begin failures++; $display("[TB] FAIL dmid_error_time got=%0d expected=15", last_err_cyc - last_bnd); end
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("[TB] FAIL dmid_valid_count got=%0d expected=0", valid_cnt - v0); end
    checks++; if (data_out !== last_good) begin failures++; $display("[TB] FAIL dmid_data_kept got=%h expected=%h", data_out, last_good); end
  endtask

  task automatic test_mid_reset;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(26'h1ABCDEF, 8);
    checks++; if (busy_out !== 1'b1) begin failures++; $display("[TB] FAIL mreset_busy_before got=%b expected=1", busy_out); end
    rst_in = 1'b0;
    data_in = 1'b0;
    idle(1);
    rst_in = 1'b1;
    checks++; if (busy_out !== 1'b0) begin failures++; $display("[TB] FAIL mreset_busy_after got=%b expected=0", busy_out); end
    checks++; if (data_out !== '0) begin failures++; $display("[TB] FAIL mreset_data got=%h expected=0", data_out); end
    idle(60);
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("[TB] FAIL mreset_valid_count got=%0d expected=0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("[TB] FAIL mreset_error_count got=%0d expected=0", err_cnt - e0); end
    send_frame(26'h1234567);
    idle(60);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("[TB] FAIL mreset_next_valid got=%0d expected=1", valid_cnt - v0); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL mreset_outstanding got=%0d expected=0", exp_q.size()); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("[TB] FAIL mreset_next_error got=%0d expected=0", err_cnt - e0); end
  endtask

  initial begin
    rst_in = 1'b0;
    data_in = 1'b0;
    test_reset();
    test_single();
    test_extremes();
    test_back_to_back();
    test_stuck();
    test_glitch();
    test_double_mid();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
